rr_arbiter8: RTL and testbench

RR_ARBITER8 -- requirements
Module: rr_arbiter8

---
 rtl/rr_arbiter8_pkg.sv | 12 +
 rtl/rr_pick8.sv | 28 ++
 rtl/rr_arbiter8.sv | 102 ++++++++++
 tb/tb_rr_arbiter8.sv | 132 +++++++++++++
 4 files changed

// File: rtl/rr_arbiter8_pkg.sv
// rr_arbiter8_pkg: shared sizes and FSM state encoding for the 8-way round-robin arbiter
//   N_REQ   - number of requesters
//   IDX_W   - width of a requester index
//   state_t - arbiter FSM states (IDLE, GRANT)
package rr_arbiter8_pkg;
    localparam int N_REQ = 8;
    localparam int IDX_W = 3;
    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;
endpackage

// File: rtl/rr_pick8.sv
// rr_pick8: rotating first-set search over 8 request bits
//   req   [7:0] in  - request vector
//   start [2:0] in  - index where the search begins (wraps 7 -> 0)
//   idx   [2:0] out - first set index at or after start, modulo 8
//   found       out - any request bit set
module rr_pick8
    import rr_arbiter8_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] start,
    output logic [IDX_W-1:0] idx,
    output logic             found
);
    logic [IDX_W-1:0] w_j;
    // Scan farthest offset first so the nearest set bit in search order wins.
    always_comb begin
        idx   = '0;
        found = 1'b0;
        w_j   = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            w_j = start + IDX_W'(k);
            if (req[w_j]) begin
                idx   = w_j;
                found = 1'b1;
            end
        end
    end
endmodule

// File: rtl/rr_arbiter8.sv
// rr_arbiter8: 8-way round-robin arbiter with hold-time limited grants
//   MAX_HOLD       - grant cycles before forced rotation when others wait (2..255)
//   clk            in  - clock, rising edge
//   rst_n          in  - asynchronous active-low reset
//   req      [7:0] in  - request lines
//   grant_idx[2:0] out - registered granted index
//   grant_en       out - registered grant valid
//   preempt        out - one-cycle pulse on timeout rotation
module rr_arbiter8
    import rr_arbiter8_pkg::*;
#(
    parameter int MAX_HOLD = 16
)
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    output logic [IDX_W-1:0] grant_idx,
    output logic             grant_en,
    output logic             preempt
);
    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

    state_t           r_state;
    logic [IDX_W-1:0] r_ptr;
    logic [IDX_W-1:0] r_grant_idx;
    logic             r_grant_en;
    logic             r_preempt;
    logic [7:0]       r_hold;

    logic [IDX_W-1:0] w_idle_idx;
    logic             w_idle_found;
    logic [IDX_W-1:0] w_pre_idx;
    logic             w_pre_found;
    logic [N_REQ-1:0] w_others;
    logic [IDX_W-1:0] w_next_ptr;

    // Holder's own bit is masked so the preempt pick only sees competitors.
    assign w_others   = req & ~(N_REQ'(1) << r_grant_idx);
    assign w_next_ptr = r_grant_idx + IDX_W'(1);

    rr_pick8 u_pick_idle (
        .req   (req),
        .start (r_ptr),
        .idx   (w_idle_idx),
        .found (w_idle_found)
    );

    rr_pick8 u_pick_pre (
        .req   (w_others),
        .start (w_next_ptr),
        .idx   (w_pre_idx),
        .found (w_pre_found)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_ptr       <= '0;
            r_grant_idx <= '0;
            r_grant_en  <= 1'b0;
            r_preempt   <= 1'b0;
            r_hold      <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_preempt <= 1'b0;
                    if (w_idle_found) begin
                        r_grant_idx <= w_idle_idx;
                        r_grant_en  <= 1'b1;
                        r_hold      <= '0;
                        r_state     <= GRANT;
                    end else begin
                        r_grant_en <= 1'b0;
                    end
                end
                GRANT: begin
                    // Release wins over timeout in the same cycle.
                    if (!req[r_grant_idx]) begin
                        r_grant_en <= 1'b0;
                        r_preempt  <= 1'b0;
                        r_ptr      <= w_next_ptr;
                        r_state    <= IDLE;
                    end else if (r_hold == HOLD_LAST && w_pre_found) begin
                        r_grant_idx <= w_pre_idx;
                        r_ptr       <= w_next_ptr;
                        r_hold      <= '0;
                        r_preempt   <= 1'b1;
                    end else begin
                        r_hold    <= (r_hold == HOLD_LAST) ? r_hold : r_hold + 8'd1;
                        r_preempt <= 1'b0;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign grant_idx = r_grant_idx;
    assign grant_en  = r_grant_en;
    assign preempt   = r_preempt;
endmodule

// File: tb/tb_rr_arbiter8.sv
// tb_rr_arbiter8: directed self-checking bench for rr_arbiter8 (MAX_HOLD=4)
module tb_rr_arbiter8;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] req;
    logic [2:0] grant_idx;
    logic       grant_en;
    logic       preempt;
    int         n_tests = 0;
    int         n_fail  = 0;

    rr_arbiter8 #(.MAX_HOLD(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .grant_idx (grant_idx),
        .grant_en  (grant_en),
        .preempt   (preempt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [2:0] order [9];
        rst_n = 1'b0;
        req   = 8'h00;
        repeat (2) @(negedge clk);
        chk("rst_en", 32'(grant_en), 32'd0);
        chk("rst_idx", 32'(grant_idx), 32'd0);
        chk("rst_pre", 32'(preempt), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_en", 32'(grant_en), 32'd0);

        req = 8'b0000_0100;
        @(negedge clk);
        chk("g2_en", 32'(grant_en), 32'd1);
        chk("g2_idx", 32'(grant_idx), 32'd2);
        req = 8'h00;
        @(negedge clk);
        chk("rel2_en", 32'(grant_en), 32'd0);
        chk("rel2_ptr", 32'(dut.r_ptr), 32'd3);

        req = 8'b1000_0011;
        @(negedge clk);
        chk("g7_idx", 32'(grant_idx), 32'd7);
        chk("g7_en", 32'(grant_en), 32'd1);
        req = 8'b0000_0011;
        @(negedge clk);
        chk("rel7_en", 32'(grant_en), 32'd0);
        chk("rel7_ptr", 32'(dut.r_ptr), 32'd0);
        @(negedge clk);
        chk("wrap_en", 32'(grant_en), 32'd1);
        chk("wrap_idx", 32'(grant_idx), 32'd0);
        req = 8'h00;
        @(negedge clk);
        chk("rel0_en", 32'(grant_en), 32'd0);

        req = 8'h22;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk($sformatf("hold1_idx_%0d", i), 32'(grant_idx), 32'd1);
            chk($sformatf("hold1_en_%0d", i), 32'(grant_en), 32'd1);
            chk($sformatf("hold1_pre_%0d", i), 32'(preempt), 32'd0);
        end
        @(negedge clk);
        chk("pre5_idx", 32'(grant_idx), 32'd5);
        chk("pre5_en", 32'(grant_en), 32'd1);
        chk("pre5_pre", 32'(preempt), 32'd1);
        @(negedge clk);
        chk("pre5_pulse_end", 32'(preempt), 32'd0);
        chk("pre5_keep", 32'(grant_idx), 32'd5);
        req = 8'h00;
        @(negedge clk);
        chk("rel5_en", 32'(grant_en), 32'd0);
        chk("rel5_ptr", 32'(dut.r_ptr), 32'd6);

        req = 8'h40;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk($sformatf("solo6_idx_%0d", i), 32'(grant_idx), 32'd6);
            chk($sformatf("solo6_pre_%0d", i), 32'(preempt), 32'd0);
        end
        req = 8'h41;
        @(negedge clk);
        chk("late_pre_idx", 32'(grant_idx), 32'd0);
        chk("late_pre_pre", 32'(preempt), 32'd1);
        chk("late_pre_en", 32'(grant_en), 32'd1);
        req = 8'h00;
        @(negedge clk);
        chk("rel_late_en", 32'(grant_en), 32'd0);
        chk("rel_late_ptr", 32'(dut.r_ptr), 32'd1);

        req = 8'h20;
        @(negedge clk);
        chk("g5b_idx", 32'(grant_idx), 32'd5);
        #2 rst_n = 1'b0;
        #1;
        chk("async_en", 32'(grant_en), 32'd0);
        chk("async_idx", 32'(grant_idx), 32'd0);
        chk("async_ptr", 32'(dut.r_ptr), 32'd0);
        req = 8'hFF;
        @(negedge clk);
        chk("inrst_en", 32'(grant_en), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        order = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0};
        for (int i = 0; i < 9; i++) begin
            chk($sformatf("rr_en_a_%0d", i), 32'(grant_en), 32'd1);
            chk($sformatf("rr_idx_a_%0d", i), 32'(grant_idx), 32'(order[i]));
            @(negedge clk);
            chk($sformatf("rr_idx_b_%0d", i), 32'(grant_idx), 32'(order[i]));
            req = 8'hFF & ~(8'h01 << order[i]);
            @(negedge clk);
            chk($sformatf("rr_gap_%0d", i), 32'(grant_en), 32'd0);
            req = 8'hFF;
            @(negedge clk);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
